// File: rtl/tbird_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// Lamp patterns are built at MAX_LAMPS width and truncated by the user.
package tbird_pkg;

  localparam int MAX_LAMPS = 32;

  typedef enum logic [1:0] {IDLE, LEFT_SEQ, RIGHT_SEQ, HAZ} state_t;
  typedef enum logic [1:0] {MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ} mode_t;

  // Thermometer of k ones filled from bit 0 upward.
  function automatic logic [MAX_LAMPS-1:0] therm_lo(input int k);
    logic [MAX_LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < k) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic state_t mode_to_state(input mode_t m);
    case (m)
      MODE_LEFT:  return LEFT_SEQ;
      MODE_RIGHT: return RIGHT_SEQ;
      MODE_HAZ:   return HAZ;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tbird_tick_gen.sv
// Step-rate divider: tick is a combinational one-cycle pulse on the last count of each period.
// No backpressure; clr or !en parks the count at zero.
module tbird_tick_gen #(
  parameter int TICK_DIV = 67108864,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // A clear on the same edge as the last count suppresses the step.
  assign tick = en & ~clr & (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tbird_seq_lights.sv
// Tail-light sequencer (turn sweep, hazard flash); all outputs registered, one edge after inputs.
// No backpressure. Optional brake overlay enabled by macro TBIRD_BRAKE_EN.
module tbird_seq_lights
  import tbird_pkg::*;
#(
  parameter  int LAMPS    = 3,
  parameter  int TICK_DIV = 67108864,
  localparam int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sign_left,
  input  logic             sign_right,
  input  logic             hazard,
`ifdef TBIRD_BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] L,
  output logic [LAMPS-1:0] R,
  output logic             active
);

  localparam int K_W = $clog2(LAMPS + 1);
  localparam logic [LAMPS-1:0] ALL_ON = '1;

  state_t           state, state_tgt;
  mode_t            mode;
  logic [K_W-1:0]   k, k_nxt;
  logic             mode_chg, tick, brake_on;
  logic [LAMPS-1:0] l_thm, r_thm, l_nxt, r_nxt;

`ifdef TBIRD_BRAKE_EN
  assign brake_on = brake;
`else
  assign brake_on = 1'b0;
`endif

  always_comb begin
    mode = MODE_IDLE;
    if (hazard || (sign_left && sign_right)) mode = MODE_HAZ;
    else if (sign_left)                      mode = MODE_LEFT;
    else if (sign_right)                     mode = MODE_RIGHT;
  end

  assign state_tgt = mode_to_state(mode);
  assign mode_chg  = (state_tgt != state);

  tbird_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (mode_chg),
    .en      (state != IDLE),
    .tick    (tick)
  );

  // Step index; a mode change restarts from k=0 and discards a coincident tick.
  always_comb begin
    k_nxt = k;
    if (mode_chg) begin
      k_nxt = '0;
    end else if (tick) begin
      case (state)
        LEFT_SEQ, RIGHT_SEQ: k_nxt = (k == K_W'(LAMPS)) ? '0 : k + K_W'(1);
        HAZ:                 k_nxt = {{(K_W-1){1'b0}}, ~k[0]};
        default:             k_nxt = '0;
      endcase
    end
  end

  always_comb begin
    l_thm = LAMPS'(therm_lo(int'(k_nxt)));
    r_thm = '0;
    for (int i = 0; i < LAMPS; i++) r_thm[i] = l_thm[LAMPS-1-i];

    l_nxt = '0;
    r_nxt = '0;
    case (state_tgt)
      LEFT_SEQ:  l_nxt = l_thm;
      RIGHT_SEQ: r_nxt = r_thm;
      HAZ: begin
        if (k_nxt[0]) begin
          l_nxt = ALL_ON;
          r_nxt = ALL_ON;
        end
      end
      default: ;
    endcase

    // Brake lights the side not sweeping; hazard flash takes precedence.
    if (brake_on) begin
      case (state_tgt)
        IDLE: begin
          l_nxt = ALL_ON;
          r_nxt = ALL_ON;
        end
        LEFT_SEQ:  r_nxt = ALL_ON;
        RIGHT_SEQ: l_nxt = ALL_ON;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      k      <= '0;
      L      <= '0;
      R      <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_tgt;
      k      <= k_nxt;
      L      <= l_nxt;
      R      <= r_nxt;
      active <= (state_tgt != IDLE);
    end
  end

endmodule

// File: tb/tb_tbird_seq_lights.sv
// Scoreboard bench for tbird_seq_lights with LAMPS=3, TICK_DIV=4.
module tb_tbird_seq_lights;

  logic       clock;
  logic       reset_n;
  logic       sign_left, sign_right, hazard;
`ifdef TBIRD_BRAKE_EN
  logic       brake;
`endif
  logic [2:0] L, R;
  logic       active;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  tbird_seq_lights #(.LAMPS(3), .TICK_DIV(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sign_left  (sign_left),
    .sign_right (sign_right),
    .hazard     (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake      (brake),
`endif
    .L          (L),
    .R          (R),
    .active     (active)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare 1 time unit after it.
  task automatic cyc(input logic [2:0] el, input logic [2:0] er, input logic ea, input string tag);
    logic [6:0] e;
    string      t;
    exp_q.push_back({el, er, ea});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {25'd0, L, R, active}, {25'd0, e});
  endtask

  task automatic run(input int n, input logic [2:0] el, input logic [2:0] er, input logic ea,
                     input string tag);
    for (int i = 0; i < n; i++) cyc(el, er, ea, tag);
  endtask

  initial begin
    clock = 1'b0; reset_n = 1'b0;
    sign_left = 1'b0; sign_right = 1'b0; hazard = 1'b0;
`ifdef TBIRD_BRAKE_EN
    brake = 1'b0;
`endif
    #2 chk("rst_state", {29'd0, L, R, active}, 32'd0);
    #10 reset_n = 1'b1;
    run(2, 3'b000, 3'b000, 1'b0, "idle");

    // 1: left sweep
    sign_left = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t1_l000");
    run(4, 3'b001, 3'b000, 1'b1, "t1_l001");
    run(4, 3'b011, 3'b000, 1'b1, "t1_l011");
    run(4, 3'b111, 3'b000, 1'b1, "t1_l111");
    run(4, 3'b000, 3'b000, 1'b1, "t1_lwrap");

    // 2: right sweep, then switch straight to left at R=110
    sign_left = 1'b0; sign_right = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t2_r000");
    run(4, 3'b000, 3'b100, 1'b1, "t2_r100");
    run(2, 3'b000, 3'b110, 1'b1, "t2_r110");
    sign_left = 1'b1; sign_right = 1'b0;
    run(4, 3'b000, 3'b000, 1'b1, "t2_sw_dark");
    run(1, 3'b001, 3'b000, 1'b1, "t2_sw_l001");
    sign_left = 1'b0;
    run(1, 3'b000, 3'b000, 1'b0, "t2_drop");

    // 3: hazard by both turn signals, then by hazard input
    sign_left = 1'b1; sign_right = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t3_haz_dark");
    run(4, 3'b111, 3'b111, 1'b1, "t3_haz_on");
    run(4, 3'b000, 3'b000, 1'b1, "t3_haz_off");
    run(4, 3'b111, 3'b111, 1'b1, "t3_haz_on2");
    sign_left = 1'b0; sign_right = 1'b0;
    run(2, 3'b000, 3'b000, 1'b0, "t3_drop");
    hazard = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t3_hz_dark");
    run(2, 3'b111, 3'b111, 1'b1, "t3_hz_on");
    sign_left = 1'b1;
    run(2, 3'b111, 3'b111, 1'b1, "t3_hz_prio");
    run(2, 3'b000, 3'b000, 1'b1, "t3_hz_prio_off");
    hazard = 1'b0; sign_left = 1'b0;
    run(1, 3'b000, 3'b000, 1'b0, "t3_hz_drop");

    // 4: asynchronous reset mid-sweep
    sign_left = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t4_l000");
    run(4, 3'b001, 3'b000, 1'b1, "t4_l001");
    run(2, 3'b011, 3'b000, 1'b1, "t4_l011");
    #2 reset_n = 1'b0;
    #1 chk("t4_async_rst", {29'd0, L, R, active}, 32'd0);
    #2 reset_n = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t4_restart");
    run(4, 3'b001, 3'b000, 1'b1, "t4_re_l001");

    // 5: request dropped on the tick edge that would show 111
    run(4, 3'b011, 3'b000, 1'b1, "t5_l011");
    sign_left = 1'b0;
    run(2, 3'b000, 3'b000, 1'b0, "t5_drop_tick");

`ifdef TBIRD_BRAKE_EN
    // 6: brake overlay
    brake = 1'b1;
    run(2, 3'b111, 3'b111, 1'b0, "t6_brk_idle");
    sign_left = 1'b1;
    run(4, 3'b000, 3'b111, 1'b1, "t6_brk_l000");
    run(4, 3'b001, 3'b111, 1'b1, "t6_brk_l001");
    run(4, 3'b011, 3'b111, 1'b1, "t6_brk_l011");
    run(4, 3'b111, 3'b111, 1'b1, "t6_brk_l111");
    hazard = 1'b1;
    run(4, 3'b000, 3'b000, 1'b1, "t6_brk_haz_dark");
    run(4, 3'b111, 3'b111, 1'b1, "t6_brk_haz_on");
    run(2, 3'b000, 3'b000, 1'b1, "t6_brk_haz_off");
    hazard = 1'b0; sign_left = 1'b0;
    run(1, 3'b111, 3'b111, 1'b0, "t6_brk_idle2");
    brake = 1'b0;
    run(1, 3'b000, 3'b000, 1'b0, "t6_brk_rel");
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
